// File: rtl/snake_food_if.sv
// -----------------------------------------------------------------------------
// snake_food_if
//   Bundle between the snake core / renderer side and snake_food_ctrl.
//   master : snake_food_ctrl (consumes the core state, drives the food outputs)
//   slave  : core + renderer side (drives the core state, consumes the food)
//
//   tick        game-step pulse, same one driving the snake core
//   head_x/y    head position in pixels
//   length      snake length including head
//   body_bus_x  MAX_LEN packed 10-bit x; MSB slice is segment 0 (the head)
//   body_bus_y  MAX_LEN packed 9-bit y; same packing
//   food_x/y    food position in pixels (multiple of the cell size)
//   food_valid  food placed and displayable
//   eat_evt     1-cycle pulse when the head reaches the food
//   score       eats counter, saturating at 255
//   busy        food placement in progress
// -----------------------------------------------------------------------------
interface snake_food_if #(
   parameter int MAX_LEN = 33
);
   logic                  tick;
   logic [9:0]            head_x;
   logic [8:0]            head_y;
   logic [7:0]            length;
   logic [MAX_LEN*10-1:0] body_bus_x;
   logic [MAX_LEN*9-1:0]  body_bus_y;
   logic [9:0]            food_x;
   logic [8:0]            food_y;
   logic                  food_valid;
   logic                  eat_evt;
   logic [7:0]            score;
   logic                  busy;

   modport master (
      input  tick, head_x, head_y, length, body_bus_x, body_bus_y,
      output food_x, food_y, food_valid, eat_evt, score, busy
   );

   modport slave (
      output tick, head_x, head_y, length, body_bus_x, body_bus_y,
      input  food_x, food_y, food_valid, eat_evt, score, busy
   );
endinterface

// File: rtl/snake_food_ctrl.sv
// -----------------------------------------------------------------------------
// snake_food_ctrl
//   Places food on a random free grid cell, detects the head landing on it,
//   pulses eat_evt for one cycle, bumps the score and places new food.
//   Runs in the clk_pix domain between the snake core and the pixel renderer.
//
// Ports
//   clk_pix  pixel clock
//   reset_n  synchronous, active-low reset
//   fif      snake_food_if.master (core state in, food/score/status out)
//
// Optional feature
//   SNAKE_FOOD_TIMEOUT_EN : when defined, uneaten food relocates after
//   TIMEOUT_TICKS game ticks (no eat_evt, score unchanged). When undefined
//   the food stays until eaten.
//
// Note: MAX_LEN must match the MAX_LEN of the connected interface instance.
// -----------------------------------------------------------------------------
module snake_food_ctrl #(
   parameter int          CELL          = 10,
   parameter int          GRID_W        = 64,
   parameter int          GRID_H        = 48,
   parameter int          MAX_LEN       = 33,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          TIMEOUT_TICKS = 200
) (
   input  logic         clk_pix,
   input  logic         reset_n,
   snake_food_if.master fif
);

   localparam int          KW        = $clog2(MAX_LEN);
   localparam logic [KW-1:0] K_LAST  = KW'(MAX_LEN - 1);
   // Galois taps for x^16+x^14+x^13+x^11+1 in the right-shifting form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   // Border cells are never used, so the candidate must sit in 1..W-2 / 1..H-2
   localparam logic [5:0]  CX_MAX    = 6'(GRID_W - 2);
   localparam logic [5:0]  CY_MAX    = 6'(GRID_H - 2);
   localparam logic [9:0]  CELL_PX   = 10'(CELL);
   localparam logic [8:0]  CELL_PY   = 9'(CELL);

   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("snake_food_ctrl: LFSR_SEED must be non-zero");
   end
   if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_timeout
      $error("snake_food_ctrl: TIMEOUT_TICKS must fit the 8-bit tick counter");
   end

   typedef enum logic [1:0] {
      ST_GEN   = 2'd0,
      ST_CHECK = 2'd1,
      ST_ARMED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic          tick_d_q;
   logic [KW-1:0] k_q, k_d;
   logic [9:0]    cand_x_q, cand_x_d;
   logic [8:0]    cand_y_q, cand_y_d;
   logic [9:0]    food_x_q, food_x_d;
   logic [8:0]    food_y_q, food_y_d;
   logic          food_valid_q, food_valid_d;
   logic          eat_evt_q, eat_evt_d;
   logic [7:0]    score_q, score_d;
   logic          busy_q, busy_d;

   // ---------------------------------------------------------------------------
   // Unpack the body buses; segment 0 (head) lives in the MSB slice.
   // ---------------------------------------------------------------------------
   logic [9:0] seg_x [MAX_LEN];
   logic [8:0] seg_y [MAX_LEN];

   for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
      assign seg_x[g] = fif.body_bus_x[10*(MAX_LEN-1-g) +: 10];
      assign seg_y[g] = fif.body_bus_y[9*(MAX_LEN-1-g) +: 9];
   end

   // ---------------------------------------------------------------------------
   // Candidate decode and match terms
   // ---------------------------------------------------------------------------
   logic [5:0] cx, cy;
   logic       cand_ok;
   logic [9:0] cx_px;
   logic [8:0] cy_px;
   logic       in_len;
   logic       seg_hit;
   logic       k_last;
   logic       head_hit;
   logic       tmo_hit;

   assign cx      = lfsr_q[5:0];
   assign cy      = lfsr_q[11:6];
   assign cand_ok = (cx != 6'd0) && (cx <= CX_MAX) && (cy != 6'd0) && (cy <= CY_MAX);
   assign cx_px   = {4'b0, cx} * CELL_PX;
   assign cy_px   = {3'b0, cy} * CELL_PY;

   // Segments at or beyond the current length are stale and ignored. A length
   // above MAX_LEN simply leaves every slice enabled.
   assign in_len   = (8'(k_q) < fif.length);
   assign seg_hit  = in_len && (seg_x[k_q] == cand_x_q) && (seg_y[k_q] == cand_y_q);
   assign k_last   = (k_q == K_LAST);
   // The core moves the head on tick; it is stable one cycle later.
   assign head_hit = tick_d_q && (fif.head_x == food_x_q) && (fif.head_y == food_y_q);

`ifdef SNAKE_FOOD_TIMEOUT_EN
   logic [7:0] tmo_q, tmo_d;

   // Counter is evaluated on the tick_d cycle so that an eat on the same
   // head update takes priority over the relocation.
   assign tmo_hit = tick_d_q && (tmo_q == 8'(TIMEOUT_TICKS));

   always_comb begin
      tmo_d = tmo_q;
      if (state_q != ST_ARMED && state_d == ST_ARMED) begin
         tmo_d = 8'd0;
      end else if (state_q == ST_ARMED && fif.tick) begin
         tmo_d = tmo_q + 8'd1;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (!reset_n) begin
         tmo_q <= 8'd0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // State register (and all datapath flops)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_pix) begin
      if (!reset_n) begin
         state_q      <= ST_GEN;
         lfsr_q       <= LFSR_SEED;
         tick_d_q     <= 1'b0;
         k_q          <= '0;
         cand_x_q     <= 10'd0;
         cand_y_q     <= 9'd0;
         food_x_q     <= 10'd0;
         food_y_q     <= 9'd0;
         food_valid_q <= 1'b0;
         eat_evt_q    <= 1'b0;
         score_q      <= 8'd0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         tick_d_q     <= fif.tick;
         k_q          <= k_d;
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
         eat_evt_q    <= eat_evt_d;
         score_q      <= score_d;
         busy_q       <= busy_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_GEN: begin
            if (cand_ok) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            // A tick on the last slice restarts the scan instead of placing,
            // because the buses just shifted under us.
            if (seg_hit)                 state_d = ST_GEN;
            else if (!fif.tick && k_last) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (head_hit || tmo_hit) state_d = ST_GEN;
         end
         default: state_d = ST_GEN;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output / datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // LFSR free-runs every cycle regardless of state
      lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      k_d          = k_q;
      cand_x_d     = cand_x_q;
      cand_y_d     = cand_y_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      eat_evt_d    = 1'b0;
      score_d      = score_q;
      busy_d       = (state_d != ST_ARMED);

      unique case (state_q)
         ST_GEN: begin
            if (cand_ok) begin
               cand_x_d = cx_px;
               cand_y_d = cy_px;
               k_d      = '0;
            end
         end
         ST_CHECK: begin
            if (!seg_hit) begin
               if (fif.tick) begin
                  k_d = '0;
               end else if (k_last) begin
                  food_x_d     = cand_x_q;
                  food_y_d     = cand_y_q;
                  food_valid_d = 1'b1;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         ST_ARMED: begin
            if (head_hit) begin
               eat_evt_d    = 1'b1;
               food_valid_d = 1'b0;
               score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            end else if (tmo_hit) begin
               food_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign fif.food_x     = food_x_q;
   assign fif.food_y     = food_y_q;
   assign fif.food_valid = food_valid_q;
   assign fif.eat_evt    = eat_evt_q;
   assign fif.score      = score_q;
   assign fif.busy       = busy_q;

endmodule

// File: tb/tb_snake_food_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_snake_food_ctrl
//   Directed bench for snake_food_ctrl. A behavioural model (food present /
//   scanning / generating, driven from the LFSR sequence and the bench's own
//   segment arrays) is compared against the DUT every cycle; literal checks
//   pin reset values, the first placement, eat timing and score saturation.
// -----------------------------------------------------------------------------
module tb_snake_food_ctrl;
   localparam int          MAX_LEN = 33;
   localparam int          CELL    = 10;
   localparam int          GRID_W  = 64;
   localparam int          GRID_H  = 48;
   localparam logic [15:0] SEED    = 16'hACE1;
   localparam int          TMO     = 3;

   logic clk_pix = 1'b0;
   logic reset_n = 1'b0;

   snake_food_if #(.MAX_LEN(MAX_LEN)) fif ();

   snake_food_ctrl #(
      .CELL(CELL), .GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN),
      .LFSR_SEED(SEED), .TIMEOUT_TICKS(TMO)
   ) dut (
      .clk_pix(clk_pix),
      .reset_n(reset_n),
      .fif(fif)
   );

   always #5 clk_pix = ~clk_pix;

   int checks  = 0;
   int errors  = 0;
   int eat_cnt = 0;

   logic [9:0] sx [MAX_LEN];
   logic [8:0] sy [MAX_LEN];

   // ---------------- behavioural model ----------------
   bit          m_live = 1'b0;
   logic [15:0] m_lfsr;
   bit          m_tick_d, m_fv, m_eat, m_busy, m_hit, m_tick_now;
   int          m_pos, m_score, m_fx, m_fy, m_cx, m_cy, m_armed_ticks, c_x, c_y;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   initial forever begin
      @(posedge clk_pix);
      if (reset_n !== 1'b1) begin
         m_live = 1'b1; m_lfsr = SEED; m_tick_d = 0; m_fv = 0; m_eat = 0;
         m_busy = 0; m_pos = -1; m_score = 0; m_fx = 0; m_fy = 0;
         m_cx = 0; m_cy = 0; m_armed_ticks = 0;
      end else begin
         m_tick_now = fif.tick;
         m_eat = 0;
         if (m_fv) begin
            m_hit = m_tick_d && (fif.head_x == 10'(m_fx)) && (fif.head_y == 9'(m_fy));
            if (m_hit) begin
               m_eat = 1; m_fv = 0; m_pos = -1;
               if (m_score < 255) m_score++;
            end
`ifdef SNAKE_FOOD_TIMEOUT_EN
            else if (m_tick_d && m_armed_ticks == TMO) begin
               m_fv = 0; m_pos = -1;
            end
            if (m_tick_now) m_armed_ticks++;
`endif
         end else if (m_pos < 0) begin
            c_x = int'(m_lfsr[5:0]);
            c_y = int'(m_lfsr[11:6]);
            if (c_x >= 1 && c_x <= GRID_W-2 && c_y >= 1 && c_y <= GRID_H-2) begin
               m_cx = c_x * CELL; m_cy = c_y * CELL; m_pos = 0;
            end
         end else begin
            if (m_pos < int'(fif.length) && sx[m_pos] == 10'(m_cx) && sy[m_pos] == 9'(m_cy))
               m_pos = -1;
            else if (m_tick_now)
               m_pos = 0;
            else if (m_pos == MAX_LEN-1) begin
               m_fv = 1; m_fx = m_cx; m_fy = m_cy; m_armed_ticks = 0;
            end else
               m_pos++;
         end
         m_busy   = !m_fv;
         m_tick_d = m_tick_now;
         m_lfsr   = lfsr_step(m_lfsr);
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk_pix);
      if (m_live) begin
         checks++;
         if (fif.food_x !== 10'(m_fx) || fif.food_y !== 9'(m_fy) || fif.food_valid !== m_fv ||
             fif.eat_evt !== m_eat || fif.score !== 8'(m_score) || fif.busy !== m_busy) begin
            errors++;
            $display("FAIL model_cmp t=%0t got fx=%0d fy=%0d fv=%b eat=%b sc=%0d busy=%b required fx=%0d fy=%0d fv=%b eat=%b sc=%0d busy=%b",
                     $time, fif.food_x, fif.food_y, fif.food_valid, fif.eat_evt, fif.score, fif.busy,
                     m_fx, m_fy, m_fv, m_eat, m_score, m_busy);
         end
      end
   end

   initial forever begin
      @(negedge clk_pix);
      if (fif.eat_evt === 1'b1) eat_cnt++;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic pack_body();
      for (int i = 0; i < MAX_LEN; i++) begin
         fif.body_bus_x[10*(MAX_LEN-1-i) +: 10] = sx[i];
         fif.body_bus_y[9*(MAX_LEN-1-i) +: 9]   = sy[i];
      end
      fif.head_x = sx[0];
      fif.head_y = sy[0];
   endtask

   task automatic shift_body(input logic [9:0] hx, input logic [8:0] hy);
      for (int i = MAX_LEN-1; i > 0; i--) begin
         sx[i] = sx[i-1]; sy[i] = sy[i-1];
      end
      sx[0] = hx; sy[0] = hy;
      pack_body();
   endtask

   task automatic clear_body();
      for (int i = 0; i < MAX_LEN; i++) begin sx[i] = '0; sy[i] = '0; end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk_pix);
      reset_n = 1'b1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (fif.food_valid !== 1'b1 && n < 2000) begin
         @(negedge clk_pix); n++;
      end
      checks++;
      if (fif.food_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s: food_valid=%b after %0d cycles, required 1", name, fif.food_valid, n);
      end
   endtask

   // food on grid interior, cell aligned, and off every active segment
   task automatic food_sane(input string name);
      int hits, lim;
      hits = 0;
      lim  = (int'(fif.length) < MAX_LEN) ? int'(fif.length) : MAX_LEN;
      for (int i = 0; i < lim; i++)
         if (sx[i] == fif.food_x && sy[i] == fif.food_y) hits++;
      chk({name, "_align"}, (fif.food_x % 10 == 0) && (fif.food_y % 10 == 0), 1);
      chk({name, "_range"}, fif.food_x >= 10 && fif.food_x <= 620 && fif.food_y >= 10 && fif.food_y <= 460, 1);
      chk({name, "_on_body"}, hits, 0);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_fx"}, fif.food_x, 0);
      chk({name, "_fy"}, fif.food_y, 0);
      chk({name, "_fv"}, fif.food_valid, 0);
      chk({name, "_eat"}, fif.eat_evt, 0);
      chk({name, "_score"}, fif.score, 0);
      chk({name, "_busy"}, fif.busy, 0);
   endtask

   // head moves onto the food with the tick; pulse lands 2 clk later
   task automatic eat_food(input string name);
      shift_body(fif.food_x, fif.food_y);
      fif.tick = 1'b1;
      @(negedge clk_pix); fif.tick = 1'b0;
      chk({name, "_eat_t1"}, fif.eat_evt, 0);
      @(negedge clk_pix);
      chk({name, "_eat_t2"}, fif.eat_evt, 1);
      chk({name, "_fv_t2"}, fif.food_valid, 0);
      @(negedge clk_pix);
      chk({name, "_eat_t3"}, fif.eat_evt, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int          base, ncell;
      logic [15:0] lf;
      int          ax, ay;
      bit          dup;

      fif.tick = 1'b0;
      fif.length = 8'd2;
      clear_body();
      sx[0] = 10'd370; sy[0] = 9'd280; sx[1] = 10'd360; sy[1] = 9'd280;
      pack_body();

      // reset values
      reset_n = 1'b0;
      repeat (3) @(negedge clk_pix);
      chk_reset_vals("rst");
      reset_n = 1'b1;

      // first placement: seed ACE1 rejects (cy=51), next E270 gives cell (48,9)
      wait_valid("first_place");
      chk("first_fx", fif.food_x, 480);
      chk("first_fy", fif.food_y, 90);
      chk("first_score", fif.score, 0);
      food_sane("first");

      // one eat with pulse timing
      eat_food("eat1");
      chk("eat1_score", fif.score, 1);
      chk("eat1_cnt", eat_cnt, 1);
      wait_valid("eat1_replace");
      chk("eat1_new_off_head", (fif.food_x != sx[0]) || (fif.food_y != sy[0]), 1);

      // full body over the early accepted candidate cells
      clear_body();
      lf = SEED; ncell = 0;
      for (int n = 0; n < 50; n++) begin
         ax = int'(lf[5:0]); ay = int'(lf[11:6]);
         if (ax >= 1 && ax <= GRID_W-2 && ay >= 1 && ay <= GRID_H-2 && ncell < MAX_LEN) begin
            dup = 0;
            for (int j = 0; j < ncell; j++)
               if (sx[j] == 10'(ax*CELL) && sy[j] == 9'(ay*CELL)) dup = 1;
            if (!dup) begin sx[ncell] = 10'(ax*CELL); sy[ncell] = 9'(ay*CELL); ncell++; end
         end
         lf = lfsr_step(lf);
      end
      fif.length = 8'd33;
      pack_body();
      do_reset();
      wait_valid("full_place");
      food_sane("full");
      chk("full_not_first_cand", (fif.food_x == 10'd480) && (fif.food_y == 9'd90), 0);

      // ticks every 5 cycles while placing
      fif.length = 8'd5;
      clear_body();
      for (int i = 0; i < 5; i++) begin sx[i] = 10'(300 - 10*i); sy[i] = 9'd200; end
      pack_body();
      do_reset();
      @(negedge clk_pix);
      base = eat_cnt;
      for (int t = 0; t < 6; t++) begin
         repeat (4) @(negedge clk_pix);
         chk("tick_busy", fif.busy, 1);
         shift_body(sx[0] + 10'd10, sy[0]);
         fif.tick = 1'b1;
         @(negedge clk_pix); fif.tick = 1'b0;
      end
      wait_valid("tick_place");
      food_sane("tick");
      chk("tick_no_eat", eat_cnt - base, 0);

      // 260 eats: score saturates, pulse keeps coming
      base = eat_cnt;
      for (int e = 0; e < 260; e++) begin
         wait_valid("sat_place");
         eat_food("sat");
      end
      chk("sat_score", fif.score, 255);
      chk("sat_pulses", eat_cnt - base, 260);

      // reset mid-placement
      repeat (8) @(negedge clk_pix);
      chk("midchk_busy", fif.busy, 1);
      reset_n = 1'b0;
      @(negedge clk_pix);
      chk_reset_vals("midchk_rst");
      reset_n = 1'b1;

      // reset while eat_evt is high
      wait_valid("midpulse_place");
      shift_body(fif.food_x, fif.food_y);
      fif.tick = 1'b1;
      @(negedge clk_pix); fif.tick = 1'b0;
      @(negedge clk_pix);
      chk("midpulse_eat_hi", fif.eat_evt, 1);
      reset_n = 1'b0;
      @(negedge clk_pix);
      chk("midpulse_eat_lo", fif.eat_evt, 0);
      chk("midpulse_score", fif.score, 0);
      chk("midpulse_fv", fif.food_valid, 0);
      reset_n = 1'b1;

`ifdef SNAKE_FOOD_TIMEOUT_EN
      // head parked on a border cell that food can never occupy
      fif.length = 8'd2;
      clear_body();
      sx[1] = 10'd0; sy[1] = 9'd10;
      pack_body();
      do_reset();
      wait_valid("tmo_place");
      base = eat_cnt;
      for (int t = 0; t < TMO; t++) begin
         repeat (6) @(negedge clk_pix);
         fif.tick = 1'b1;
         @(negedge clk_pix); fif.tick = 1'b0;
         chk("tmo_fv_t1", fif.food_valid, 1);
         @(negedge clk_pix);
         chk("tmo_fv_t2", fif.food_valid, (t == TMO-1) ? 0 : 1);
      end
      chk("tmo_no_eat", eat_cnt - base, 0);
      chk("tmo_score", fif.score, 0);
      wait_valid("tmo_replace");
`endif

      repeat (3) @(negedge clk_pix);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_food_ctrl.md
Name: snake_food_ctrl

Overview:
- Producer side of the snake core's `eat_evt` input, and consumer of its head position, length and packed body buses.
- Places food on a random free grid cell, detects when the head lands on it, and issues a 1-cycle `eat_evt` pulse.
- After each eat it increments the score and re-places the food.
- Sits between the snake core and the pixel renderer in the `clk_pix` domain.

Parameters:
- CELL, 10, cell size in pixels.
- GRID_W, 64, grid width in cells.
- GRID_H, 48, grid height in cells.
- MAX_LEN, 33, segment count carried on the body buses (head included).
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.
- TIMEOUT_TICKS, 200, ticks before uneaten food relocates (used only with the optional feature).

Ports:
- clk_pix  in  1  pixel clock.
- reset_n  in  1  reset, synchronous, active-low.
- tick  in  1  1-cycle game-step pulse, the same one driving the snake core.
- head_x  in  10  head x in pixels, updated by the core on tick.
- head_y  in  9  head y in pixels.
- length  in  8  current snake length including head.
- body_bus_x  in  MAX_LEN*10  packed segment x; MSB slice = seg0 = head.
- body_bus_y  in  MAX_LEN*9  packed segment y; same packing.
- food_x  out  10  food x in pixels (multiple of CELL).
- food_y  out  9  food y in pixels.
- food_valid  out  1  food placed and displayable.
- eat_evt  out  1  1-cycle pulse when the head reaches the food.
- score  out  8  eats counter, saturating at 255.
- busy  out  1  placement in progress (GEN or CHECK).

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Outputs: food_x=0, food_y=0, food_valid=0, eat_evt=0, score=0, busy=0.
  - State: lfsr=LFSR_SEED, state=GEN, tick_d=0, k=0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk_pix cycle out of reset, regardless of state.
- tick_d is tick delayed one clk. The head is stable and sampled when tick_d=1.
- State GEN (busy=1):
  - Candidate cells: cx=lfsr[5:0], cy=lfsr[11:6].
  - Accept only if 1<=cx<=GRID_W-2 and 1<=cy<=GRID_H-2; otherwise stay in GEN and retry next cycle.
  - On accept: latch cand_x=cx*CELL (10-bit) and cand_y=cy*CELL (9-bit), set k=0, go to CHECK.
- State CHECK (busy=1):
  - Each cycle, compare the candidate against segment k (slice of the buses), but only when k<length.
  - Match: go to GEN.
  - No match and k=MAX_LEN-1: food_x<=cand_x, food_y<=cand_y, food_valid<=1, go to ARMED.
  - Otherwise k<=k+1.
  - tick during CHECK: k<=0 (restart the scan, since the buses are shifting).
- State ARMED (busy=0):
  - When tick_d=1 and head_x==food_x and head_y==food_y: next cycle eat_evt=1 (exactly one cycle), food_valid<=0, score<=sat(score+1), go to GEN.
  - Eat latency: eat_evt is asserted 2 clk after the tick that moved the head. It must precede the next tick; ticks are far sparser.
- eat_evt is only ever asserted from ARMED; never in GEN or CHECK.
- length==MAX_LEN: placement proceeds normally; the core ignores further growth.
- length>MAX_LEN is treated as MAX_LEN (the k<length gate naturally covers every slice).
- Reset mid-CHECK or mid-pulse: everything returns to reset values; eat_evt drops immediately.
- Placement latency: at most (rejects + MAX_LEN) cycles per attempt; no retry cap.

Optional Feature:
- Macro: SNAKE_FOOD_TIMEOUT_EN.
- Defined:
  - An 8-bit tick counter clears on entry to ARMED and increments on tick while in ARMED.
  - At TIMEOUT_TICKS with no eat: food_valid<=0, go to GEN, no eat_evt, score unchanged.
  - An eat on the same tick_d cycle as the timeout wins.
- Undefined: no counter; food stays until eaten.

Test Plan:
- Reset, length=2, body at (370,280),(360,280), no ticks → food_valid rises within 2000 cycles. food_x and food_y are multiples of 10 in 10..620 / 10..460 and differ from both segments. score=0.
- After food_valid, drive head=(food_x,food_y) and pulse tick → eat_evt high exactly one cycle, 2 clk after tick. score=1, food_valid=0 the same cycle, then a new valid food.
- Body filled so that all 33 segments cover the candidate cells of the first 50 LFSR outputs → placed food never equals any segment with index < length.
- Pulse tick every 5 cycles while busy=1 → CHECK restarts, eat_evt stays 0, and the final food avoids the post-shift body.
- Perform 260 eats → score saturates at 255; eat_evt still pulses each time.
- SNAKE_FOOD_TIMEOUT_EN defined, TIMEOUT_TICKS=3, head kept away → food relocates after the 3rd tick with no eat_evt and score unchanged.
